// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution stream controller.
package conv_pkg;

  localparam int unsigned DefM       = 480;
  localparam int unsigned DefN       = 640;
  localparam int unsigned DefK       = 3;
  localparam int unsigned DefPipeLat = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // v: full KxK window inside the frame; l: last pixel of the frame.
  typedef struct packed {
    logic v;
    logic l;
  } tag_t;

endpackage

// File: rtl/conv_tag_pipe.sv
// Enabled shift register carrying per-pixel tags alongside the datapath latency.
module conv_tag_pipe #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < int'(Depth); i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= din;
      for (int i = 1; i < int'(Depth); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[Depth-1];

endmodule

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for the conv datapath: raster counting, clock-enable gating,
// window tagging and AXI-Stream handshakes.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned M        = DefM,
  parameter int unsigned N        = DefN,
  parameter int unsigned K        = DefK,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic s_tvalid,
  output logic s_tready,
  input  logic s_tlast,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast,
  output logic conv_en,
  output logic zero_in,
  output logic busy,
  output logic done,
  output logic err_len
);

  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          err_q, err_d;
  logic          in_fire, last_pix;
  tag_t          tag_in, pipe_din, pipe_tail;

  assign last_pix = (row_q == RW'(M - 1)) && (col_q == CW'(N - 1));
  assign tag_in.v = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign tag_in.l = last_pix;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    drain_d  = drain_q;
    err_d    = err_q;
    s_tready = 1'b0;
    in_fire  = 1'b0;
    conv_en  = 1'b0;
    zero_in  = 1'b0;
    pipe_din = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
          drain_d = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        s_tready = m_tready;
        in_fire  = s_tvalid & m_tready;
        conv_en  = in_fire;
        pipe_din = tag_in;
        if (in_fire) begin
          // Length is fixed by parameters; s_tlast is only audited.
          if (s_tlast != last_pix) err_d = 1'b1;
          if (last_pix) begin
            state_d = StDrain;
            drain_d = '0;
          end else if (col_q == CW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        conv_en = m_tready;
        zero_in = 1'b1;
        if (m_tready) begin
          if (drain_q == DW'(PIPE_LAT - 1)) state_d = StDone;
          else drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  conv_tag_pipe #(
    .Depth(PIPE_LAT),
    .Width($bits(tag_t))
  ) u_tag_pipe (
    .clk  (clk),
    .clear(reset | (state_q == StIdle)),
    .en   (conv_en),
    .din  (pipe_din),
    .dout (pipe_tail)
  );

  // Beat is offered only when this cycle's enable would consume it.
  assign m_tvalid = pipe_tail.v & (((state_q == StRun) & s_tvalid) | (state_q == StDrain));
  assign m_tlast  = m_tvalid & pipe_tail.l;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign err_len  = err_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Self-checking bench: table of frame scenarios, randomized handshakes, reference model.
module tb_conv_stream_ctrl;

  localparam int M  = 4;
  localparam int N  = 5;
  localparam int K  = 3;
  localparam int P  = 3;
  localparam int MN = M * N;

  logic clk = 1'b0;
  logic reset, start, s_tvalid, s_tlast, m_tready;
  logic s_tready, m_tvalid, m_tlast, conv_en, zero_in, busy, done, err_len;

  always #5 clk = ~clk;

  conv_stream_ctrl #(
    .M(M), .N(N), .K(K), .PIPE_LAT(P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .conv_en (conv_en),
    .zero_in (zero_in),
    .busy    (busy),
    .done    (done),
    .err_len (err_len)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a pixel index carries a beat iff its KxK window is inside the frame.
  function automatic bit win_ok(input int idx);
    if (idx < 0 || idx >= MN) return 1'b0;
    return ((idx / N) >= K - 1) && ((idx % N) >= K - 1);
  endfunction

  typedef enum {PIdle, PRun, PDrain, PDone} phase_t;
  phase_t ph = PIdle;
  int     acc, en_cnt, dcnt;
  bit     err_m;
  int     beats, lasts, dones;

  // Compare one cycle against the model, then advance the model.
  task automatic step();
    bit en, tv;
    int pidx;
    @(negedge clk);
    en   = (ph == PRun) ? (s_tvalid && m_tready) : (ph == PDrain) ? m_tready : 1'b0;
    pidx = en_cnt - P;  // pixel whose tag sits at the pipe tail
    tv   = win_ok(pidx) && ((ph == PRun && s_tvalid) || ph == PDrain);
    chk("s_tready", s_tready, ph == PRun && m_tready);
    chk("conv_en",  conv_en,  en);
    chk("m_tvalid", m_tvalid, tv);
    chk("m_tlast",  m_tlast,  tv && pidx == MN - 1);
    chk("zero_in",  zero_in,  ph == PDrain);
    chk("busy",     busy,     ph != PIdle);
    chk("done",     done,     ph == PDone);
    chk("err_len",  err_len,  err_m);
    if (m_tvalid && m_tready) beats++;
    if (m_tlast && m_tready) lasts++;
    if (done) dones++;
    if (reset) begin
      ph    = PIdle;
      err_m = 1'b0;
    end else begin
      case (ph)
        PIdle: if (start) begin
          ph = PRun; acc = 0; en_cnt = 0; dcnt = 0; err_m = 1'b0;
        end
        PRun: if (en) begin
          en_cnt++;
          if (s_tlast != (acc == MN - 1)) err_m = 1'b1;
          acc++;
          if (acc == MN) ph = PDrain;
        end
        PDrain: if (en) begin
          en_cnt++;
          dcnt++;
          if (dcnt == P) ph = PDone;
        end
        PDone: ph = PIdle;
        default: ph = PIdle;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int vpct;        // s_tvalid probability (%)
    int rpct;        // m_tready probability (%)
    int tlast_at;    // pixel index carrying s_tlast
    bit start_noise; // spurious start pulses while busy
    int reset_at;    // assert reset once this many pixels accepted (-1: never)
    int exp_beats;
    int exp_lasts;
    int exp_dones;
    bit exp_err;
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    bit finished = 1'b0;
    beats = 0; lasts = 0; dones = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      s_tvalid = ($urandom_range(99) < v.vpct);
      m_tready = ($urandom_range(99) < v.rpct);
      s_tlast  = s_tvalid && (ph == PRun) && (acc == v.tlast_at);
      start    = (cyc == 0) || (v.start_noise && ph != PIdle && $urandom_range(5) == 0);
      reset    = (v.reset_at >= 0) && (ph == PRun) && (acc == v.reset_at);
      if (reset) s_tvalid = 1'b0;
      step();
      if (cyc > 0 && ph == PIdle) begin
        if (reset) begin
          reset = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
          @(negedge clk);
          chk("busy_after_reset", busy, 1'b0);
          chk("m_tvalid_after_reset", m_tvalid, 1'b0);
          @(posedge clk);
          #1;
        end
        finished = 1'b1;
        break;
      end
    end
    reset = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame%0d_timeout: frame did not return to idle within budget", idx);
    end
    chk($sformatf("frame%0d_beats", idx), beats, v.exp_beats);
    chk($sformatf("frame%0d_lasts", idx), lasts, v.exp_lasts);
    chk($sformatf("frame%0d_dones", idx), dones, v.exp_dones);
    chk($sformatf("frame%0d_err_len", idx), err_len, v.exp_err);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{vpct: 100, rpct: 100, tlast_at: 19, start_noise: 0, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 0};
    vecs[1] = '{vpct: 50,  rpct: 50,  tlast_at: 19, start_noise: 0, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 0};
    vecs[2] = '{vpct: 100, rpct: 100, tlast_at: 10, start_noise: 0, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 1};
    vecs[3] = '{vpct: 70,  rpct: 70,  tlast_at: 19, start_noise: 1, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 0};
    vecs[4] = '{vpct: 100, rpct: 100, tlast_at: 19, start_noise: 0, reset_at: 12,
                exp_beats: 0, exp_lasts: 0, exp_dones: 0, exp_err: 0};
    vecs[5] = '{vpct: 100, rpct: 100, tlast_at: 19, start_noise: 0, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 0};
    vecs[6] = '{vpct: 50,  rpct: 50,  tlast_at: 19, start_noise: 1, reset_at: -1,
                exp_beats: 6, exp_lasts: 1, exp_dones: 1, exp_err: 0};

    reset = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast",  m_tlast,  1'b0);
    chk("rst_conv_en",  conv_en,  1'b0);
    chk("rst_zero_in",  zero_in,  1'b0);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_done",     done,     1'b0);
    chk("rst_err_len",  err_len,  1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

    // Error from a short s_tlast must clear on the following start.
    run_frame(vecs[2], 7);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_start", err_len, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Additional randomized throttled frames.
    for (int r = 0; r < 6; r++) run_frame(vecs[1], 10 + r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
